// File: rtl/lc3_seg_scanner_pkg.sv
// Shared constants for the LC3 debug display path: register-select codes,
// blanking codes and the scan digit type.
package lc3_disp_pkg;

    localparam logic [3:0] SEL_R0  = 4'b0000;
    localparam logic [3:0] SEL_R1  = 4'b0001;
    localparam logic [3:0] SEL_R2  = 4'b0010;
    localparam logic [3:0] SEL_R3  = 4'b0011;
    localparam logic [3:0] SEL_R4  = 4'b0100;
    localparam logic [3:0] SEL_R5  = 4'b0101;
    localparam logic [3:0] SEL_R6  = 4'b0110;
    localparam logic [3:0] SEL_R7  = 4'b0111;
    localparam logic [3:0] SEL_PC  = 4'b1000;
    localparam logic [3:0] SEL_MAR = 4'b1001;
    localparam logic [3:0] SEL_MDR = 4'b1010;
    localparam logic [3:0] SEL_IR  = 4'b1011;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] DIG_OFF = 4'hF;

    typedef enum logic [1:0] {
        DIG_0 = 2'd0,
        DIG_1 = 2'd1,
        DIG_2 = 2'd2,
        DIG_3 = 2'd3
    } digit_t;

    // Active-low one-hot enable for the given digit position.
    function automatic logic [3:0] digit_enable(digit_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/lc3_seg_scanner_if.sv
// Load bus from the LC3 core into the display scanner.
interface lc3_seg_scanner_if;
    logic [15:0] disp_value;
    logic [3:0]  disp_sel;
    logic        disp_load;

    modport master (output disp_value, output disp_sel, output disp_load);
    modport slave  (input  disp_value, input  disp_sel, input  disp_load);
endinterface

// File: rtl/lc3_seg_scanner_hex7seg.sv
// Combinational hex nibble to active-low 7-segment code {g,f,e,d,c,b,a}.
module lc3_hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        unique case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/lc3_seg_scanner.sv
// Double-buffered 4-digit 7-segment scanner; new values are committed only at
// a frame boundary so a digit never shows a mix of old and new data.
module lc3_seg_scanner
    import lc3_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 2,
    parameter bit          LZ_BLANK = 1'b0
) (
    input  logic                clk_0,
    input  logic                rst,
    lc3_seg_scanner_if.slave    disp,
    output logic [7:0]          seg_output_single,
    output logic [3:0]          seg_output_sequence,
    output logic [3:0]          led_output
);
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] div_cnt, div_nxt;
    digit_t           digit, digit_nxt;
    logic [15:0]      pending, committed;
    logic [3:0]       pend_sel;
    logic             pend_valid;
    logic             div_term, frame_end;
    logic [3:0]       nibble;
    logic             lead_zero;
    logic [6:0]       seg7;
    logic [7:0]       seg_nxt;

    assign div_term  = (div_cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end = div_term && (digit == DIG_3);

    always_comb begin
        div_nxt   = div_cnt + CNT_W'(1);
        digit_nxt = digit;
        if (div_term) begin
            div_nxt   = '0;
            digit_nxt = digit_t'(digit + 2'd1);
        end
    end

    // Leading-zero test looks at the digit itself and everything above it.
    always_comb begin
        nibble    = committed[3:0];
        lead_zero = 1'b0;
        unique case (digit)
            DIG_0: nibble = committed[3:0];
            DIG_1: begin
                nibble    = committed[7:4];
                lead_zero = (committed[15:4] == '0);
            end
            DIG_2: begin
                nibble    = committed[11:8];
                lead_zero = (committed[15:8] == '0);
            end
            DIG_3: begin
                nibble    = committed[15:12];
                lead_zero = (committed[15:12] == '0);
            end
            default: nibble = committed[3:0];
        endcase
    end

    lc3_hex7seg u_hex (
        .nibble (nibble),
        .seg    (seg7)
    );

    always_comb begin
        seg_nxt = {~((digit == DIG_0) && pend_valid), seg7};
        if (LZ_BLANK && lead_zero)
            seg_nxt = SEG_OFF;
    end

    always_ff @(posedge clk_0) begin
        if (rst) begin
            div_cnt             <= '0;
            digit               <= DIG_0;
            pending             <= '0;
            pend_sel            <= '0;
            pend_valid          <= 1'b0;
            committed           <= '0;
            led_output          <= '0;
            seg_output_single   <= SEG_OFF;
            seg_output_sequence <= DIG_OFF;
        end else begin
            div_cnt             <= div_nxt;
            digit               <= digit_nxt;
            seg_output_single   <= seg_nxt;
            seg_output_sequence <= digit_enable(digit);
            // A load coinciding with the frame boundary goes straight to the committed buffer.
            if (frame_end) begin
                if (disp.disp_load) begin
                    committed  <= disp.disp_value;
                    led_output <= disp.disp_sel;
                end else if (pend_valid) begin
                    committed  <= pending;
                    led_output <= pend_sel;
                end
                pend_valid <= 1'b0;
            end else if (disp.disp_load) begin
                pending    <= disp.disp_value;
                pend_sel   <= disp.disp_sel;
                pend_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lc3_seg_scanner.sv
// Directed self-checking bench for lc3_seg_scanner; one instance without and
// one with leading-zero blanking, both fed from the same load bus.
module tb_lc3_seg_scanner;
    import lc3_disp_pkg::*;

    logic       clk_0;
    logic       rst;
    logic [7:0] seg0, seg1;
    logic [3:0] seq0, seq1, led0, led1;

    int checks   = 0;
    int failures = 0;
    int k        = 0;   // edges since reset release; edge k shows digit ((k-1)%8)/2

    lc3_seg_scanner_if bus ();

    lc3_seg_scanner #(.SCAN_DIV(2), .LZ_BLANK(1'b0)) dut0 (
        .clk_0               (clk_0),
        .rst                 (rst),
        .disp                (bus),
        .seg_output_single   (seg0),
        .seg_output_sequence (seq0),
        .led_output          (led0)
    );

    lc3_seg_scanner #(.SCAN_DIV(2), .LZ_BLANK(1'b1)) dut1 (
        .clk_0               (clk_0),
        .rst                 (rst),
        .disp                (bus),
        .seg_output_single   (seg1),
        .seg_output_sequence (seq1),
        .led_output          (led1)
    );

    initial clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_0);
        #1;
        k++;
    endtask

    task automatic advance_to(input int p);
        for (int i = 0; i < 8 && (k % 8) != p; i++) tick();
    endtask

    function automatic int digit_of(input int kk);
        return ((kk - 1) % 8) / 2;
    endfunction

    function automatic logic [3:0] exp_seq(input int kk);
        case (digit_of(kk))
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic load(input logic [15:0] v, input logic [3:0] s);
        bus.disp_value = v;
        bus.disp_sel   = s;
        bus.disp_load  = 1'b1;
    endtask

    task automatic test_reset;
        bus.disp_load  = 1'b0;
        bus.disp_value = '0;
        bus.disp_sel   = '0;
        rst = 1'b1;
        repeat (3) tick();
        k = 0;
        checks++; if (seg0 !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h exp=ff", seg0); end
        checks++; if (seq0 !== 4'b1111) begin failures++; $display("FAIL reset_seq got=%b exp=1111", seq0); end
        checks++; if (led0 !== 4'b0000) begin failures++; $display("FAIL reset_led got=%b exp=0000", led0); end
        rst = 1'b0;
        tick();
        checks++; if (seq0 !== 4'b1110) begin failures++; $display("FAIL first_seq got=%b exp=1110", seq0); end
        checks++; if (seg0 !== 8'hC0) begin failures++; $display("FAIL first_seg got=%h exp=c0", seg0); end
        checks++; if (seg1 !== 8'hC0) begin failures++; $display("FAIL first_seg_lz got=%h exp=c0", seg1); end
    endtask

    task automatic test_scan;
        int d;
        for (int i = 0; i < 8; i++) begin
            tick();
            d = digit_of(k);
            checks++; if (seq0 !== exp_seq(k)) begin failures++; $display("FAIL scan_seq k=%0d got=%b exp=%b", k, seq0, exp_seq(k)); end
            checks++; if (seq1 !== exp_seq(k)) begin failures++; $display("FAIL scan_seq_lz k=%0d got=%b exp=%b", k, seq1, exp_seq(k)); end
            checks++; if (seg0 !== 8'hC0) begin failures++; $display("FAIL scan_seg k=%0d got=%h exp=c0", k, seg0); end
            checks++; if (seg1 !== ((d == 0) ? 8'hC0 : 8'hFF)) begin failures++; $display("FAIL scan_seg_lz k=%0d got=%h exp=%h", k, seg1, (d == 0) ? 8'hC0 : 8'hFF); end
        end
    endtask

    task automatic test_load;
        logic [7:0] e [4];
        int d;
        e = '{8'h8E, 8'h92, 8'h88, 8'hB0};
        advance_to(0);
        load(16'h3A5F, SEL_PC);
        tick();
        bus.disp_load = 1'b0;
        checks++; if (seg0 !== 8'hC0) begin failures++; $display("FAIL load_nodp got=%h exp=c0", seg0); end
        tick();
        checks++; if (seg0 !== 8'h40) begin failures++; $display("FAIL load_dp_lit got=%h exp=40", seg0); end
        checks++; if (led0 !== 4'b0000) begin failures++; $display("FAIL load_led_early got=%b exp=0000", led0); end
        advance_to(0);
        checks++; if (led0 !== SEL_PC) begin failures++; $display("FAIL load_led got=%b exp=1000", led0); end
        checks++; if (seg0 !== 8'hC0) begin failures++; $display("FAIL load_old_d3 got=%h exp=c0", seg0); end
        for (int i = 0; i < 8; i++) begin
            tick();
            d = digit_of(k);
            checks++; if (seq0 !== exp_seq(k)) begin failures++; $display("FAIL load_seq k=%0d got=%b exp=%b", k, seq0, exp_seq(k)); end
            checks++; if (seg0 !== e[d]) begin failures++; $display("FAIL load_seg k=%0d got=%h exp=%h", k, seg0, e[d]); end
            checks++; if (seg1 !== e[d]) begin failures++; $display("FAIL load_seg_lz k=%0d got=%h exp=%h", k, seg1, e[d]); end
        end
    endtask

    task automatic test_midframe;
        logic [7:0] old_e [4];
        logic [7:0] e [4];
        int d;
        old_e = '{8'h8E, 8'h92, 8'h88, 8'hB0};
        e     = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        advance_to(3);
        load(16'h1234, SEL_R3);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.disp_load = 1'b0;
            d = digit_of(k);
            checks++; if (seg0 !== old_e[d]) begin failures++; $display("FAIL mid_keep k=%0d got=%h exp=%h", k, seg0, old_e[d]); end
        end
        checks++; if (led0 !== SEL_R3) begin failures++; $display("FAIL mid_led got=%b exp=0011", led0); end
        for (int i = 0; i < 8; i++) begin
            tick();
            d = digit_of(k);
            checks++; if (seg0 !== e[d]) begin failures++; $display("FAIL mid_seg k=%0d got=%h exp=%h", k, seg0, e[d]); end
            checks++; if (seg1 !== e[d]) begin failures++; $display("FAIL mid_seg_lz k=%0d got=%h exp=%h", k, seg1, e[d]); end
        end
    endtask

    task automatic test_bypass;
        logic [7:0] e [4];
        int d;
        e = '{8'h8E, 8'h86, 8'h86, 8'h83};
        advance_to(7);
        load(16'hBEEF, SEL_IR);
        tick();
        bus.disp_load = 1'b0;
        checks++; if (led0 !== SEL_IR) begin failures++; $display("FAIL bypass_led got=%b exp=1011", led0); end
        checks++; if (seg0 !== 8'hF9) begin failures++; $display("FAIL bypass_old_d3 got=%h exp=f9", seg0); end
        for (int i = 0; i < 8; i++) begin
            tick();
            d = digit_of(k);
            checks++; if (seg0 !== e[d]) begin failures++; $display("FAIL bypass_seg k=%0d got=%h exp=%h", k, seg0, e[d]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e [4];
        int d;
        e = '{8'hA1, 8'hC0, 8'hC6, 8'hF8};
        advance_to(1);
        load(16'h1111, SEL_R1);
        tick();
        checks++; if (seg0 !== 8'h8E) begin failures++; $display("FAIL b2b_d0 got=%h exp=8e", seg0); end
        load(16'h2222, SEL_R2);
        tick();
        load(16'h7C0D, SEL_MAR);
        tick();
        bus.disp_load = 1'b0;
        advance_to(0);
        checks++; if (led0 !== SEL_MAR) begin failures++; $display("FAIL b2b_led got=%b exp=1001", led0); end
        for (int i = 0; i < 8; i++) begin
            tick();
            d = digit_of(k);
            checks++; if (seg0 !== e[d]) begin failures++; $display("FAIL b2b_seg k=%0d got=%h exp=%h", k, seg0, e[d]); end
            checks++; if (seg1 !== e[d]) begin failures++; $display("FAIL b2b_seg_lz k=%0d got=%h exp=%h", k, seg1, e[d]); end
        end
    endtask

    task automatic test_lz_blank;
        logic [7:0] e0 [4];
        logic [7:0] e1 [4];
        int d;
        e0 = '{8'hA4, 8'h99, 8'hC0, 8'hC0};
        e1 = '{8'hA4, 8'h99, 8'hFF, 8'hFF};
        advance_to(1);
        load(16'h0042, SEL_R0);
        tick();
        bus.disp_load = 1'b0;
        checks++; if (seg0 !== 8'hA1) begin failures++; $display("FAIL lz_pre_d0 got=%h exp=a1", seg0); end
        advance_to(0);
        checks++; if (led0 !== SEL_R0) begin failures++; $display("FAIL lz_led got=%b exp=0000", led0); end
        for (int i = 0; i < 8; i++) begin
            tick();
            d = digit_of(k);
            checks++; if (seg0 !== e0[d]) begin failures++; $display("FAIL lz_seg k=%0d got=%h exp=%h", k, seg0, e0[d]); end
            checks++; if (seg1 !== e1[d]) begin failures++; $display("FAIL lz_seg_lz k=%0d got=%h exp=%h", k, seg1, e1[d]); end
            checks++; if (seq1 !== exp_seq(k)) begin failures++; $display("FAIL lz_seq k=%0d got=%b exp=%b", k, seq1, exp_seq(k)); end
        end
        // Reset on digit 2 with a load on the same edge: the load must be lost.
        advance_to(5);
        checks++; if (seq1 !== 4'b1011) begin failures++; $display("FAIL lz_d2_seq got=%b exp=1011", seq1); end
        rst = 1'b1;
        load(16'hFFFF, SEL_IR);
        tick();
        k = 0;
        checks++; if (seg1 !== 8'hFF) begin failures++; $display("FAIL rst_mid_seg got=%h exp=ff", seg1); end
        checks++; if (seq1 !== 4'b1111) begin failures++; $display("FAIL rst_mid_seq got=%b exp=1111", seq1); end
        checks++; if (led1 !== 4'b0000) begin failures++; $display("FAIL rst_mid_led got=%b exp=0000", led1); end
        rst = 1'b0;
        bus.disp_load = 1'b0;
        tick();
        checks++; if (seq0 !== 4'b1110) begin failures++; $display("FAIL rst_rel_seq got=%b exp=1110", seq0); end
        checks++; if (seg1 !== 8'hC0) begin failures++; $display("FAIL rst_rel_seg got=%h exp=c0", seg1); end
        tick();
        checks++; if (seg0 !== 8'hC0) begin failures++; $display("FAIL rst_nodp got=%h exp=c0", seg0); end
        advance_to(0);
        checks++; if (led0 !== 4'b0000) begin failures++; $display("FAIL rst_led_commit got=%b exp=0000", led0); end
        tick();
        checks++; if (seg0 !== 8'hC0) begin failures++; $display("FAIL rst_discard got=%h exp=c0", seg0); end
        tick();
        checks++; if (seg1 !== 8'hC0) begin failures++; $display("FAIL rst_discard_lz got=%h exp=c0", seg1); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_midframe();
        test_bypass();
        test_back_to_back();
        test_lz_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
